// File: rtl/cacheline_mem_adaptor.sv
// Adapts one-line (256-bit) L2 read/write requests into fixed 4-beat bursts on
// the 64-bit memory port, completing each with a one-cycle resp_o pulse.
module cacheline_mem_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,

   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS  = LINE_W / BURST_W;
   localparam int OFFSET = $clog2(LINE_W / 8);
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-OFFSET){1'b1}}, {OFFSET{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   buf_q, buf_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic                resp_q, resp_d;

   logic                last_beat;
   int unsigned         beat_lsb;

   assign last_beat = (cnt_q == LAST_BEAT);
   assign beat_lsb  = int'(cnt_q) * BURST_W;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      addr_d  = addr_q;
      read_d  = 1'b0;
      write_d = 1'b0;
      resp_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Read wins when both requests are raised together.
            if (read_i) begin
               state_d = S_RD;
               cnt_d   = '0;
               addr_d  = address_i & LINE_MASK;
               read_d  = 1'b1;
            end else if (write_i) begin
               state_d = S_WR;
               cnt_d   = '0;
               buf_d   = line_i;
               addr_d  = address_i & LINE_MASK;
               write_d = 1'b1;
            end
         end

         S_RD: begin
            read_d = 1'b1;
            if (resp_i) begin
               buf_d[beat_lsb +: BURST_W] = burst_i;
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = S_DONE;
                  read_d  = 1'b0;
                  addr_d  = '0;
                  resp_d  = 1'b1;
               end
            end
         end

         S_WR: begin
            write_d = 1'b1;
            if (resp_i) begin
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = S_DONE;
                  write_d = 1'b0;
                  addr_d  = '0;
                  resp_d  = 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            addr_d  = '0;
         end

         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         write_q <= write_d;
         resp_q  <= resp_d;
      end
   end

   assign line_o    = buf_q;
   assign address_o = addr_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;
   assign burst_o   = (state_q == S_WR) ? buf_q[beat_lsb +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_mem_adaptor.sv
// Self-checking bench: a TB-side memory responder drives beats with random gaps;
// expected lines, beats and pulse counts come from the transaction-level rules.
module tb_cacheline_mem_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o;
   logic [63:0]  burst_i, burst_o;
   logic         read_o, write_o, resp_i;

   int checks = 0;
   int errors = 0;
   int resp_count = 0;

   cacheline_mem_adaptor #(
      .LINE_W (256),
      .BURST_W(64),
      .ADDR_W (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .line_i   (line_i),
      .line_o   (line_o),
      .address_i(address_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .resp_o   (resp_o),
      .burst_i  (burst_i),
      .burst_o  (burst_o),
      .address_o(address_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .resp_i   (resp_i)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (resp_o) resp_count++;
   endtask

   // One complete transaction as seen by the L2 and by the memory model.
   task automatic run_txn(input string name, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [255:0] wline,
                          input logic [63:0] beats [4], input int gaps [4],
                          input int drop_after, input bit tail);
      bit           is_read;
      logic [255:0] exp_line;
      logic [31:0]  exp_addr;
      int           start_resp;
      is_read  = rd;
      exp_addr = {addr[31:5], 5'b0};
      if (is_read) for (int b = 0; b < 4; b++) exp_line[b*64 +: 64] = beats[b];
      else exp_line = wline;

      read_i = rd; write_i = wr; address_i = addr; line_i = wline; resp_i = 1'b0;
      start_resp = resp_count;
      step();
      address_i = $urandom;
      line_i    = rand_line();

      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g <= gaps[b]; g++) begin
            checks += 4;
            if (read_o !== is_read) begin errors++;
               $display("FAIL %s read_o beat%0d: got %b want %b", name, b, read_o, is_read); end
            if (write_o !== !is_read) begin errors++;
               $display("FAIL %s write_o beat%0d: got %b want %b", name, b, write_o, !is_read); end
            if (address_o !== exp_addr) begin errors++;
               $display("FAIL %s address_o: got %h want %h", name, address_o, exp_addr); end
            if (resp_o !== 1'b0) begin errors++;
               $display("FAIL %s early resp_o beat%0d: got %b want 0", name, b, resp_o); end
            if (!is_read) begin
               checks++;
               if (burst_o !== wline[b*64 +: 64]) begin errors++;
                  $display("FAIL %s burst_o beat%0d: got %h want %h", name, b, burst_o, wline[b*64 +: 64]); end
            end
            if (g < gaps[b]) begin
               resp_i  = 1'b0;
               burst_i = $urandom;
               step();
            end
         end
         burst_i = beats[b];
         resp_i  = 1'b1;
         if (b == drop_after) begin read_i = 1'b0; write_i = 1'b0; end
         step();
      end
      resp_i = 1'b0;

      checks += 5;
      if (resp_o !== 1'b1) begin errors++;
         $display("FAIL %s resp_o at done: got %b want 1", name, resp_o); end
      if (line_o !== exp_line) begin errors++;
         $display("FAIL %s line_o: got %h want %h", name, line_o, exp_line); end
      if (read_o !== 1'b0 || write_o !== 1'b0) begin errors++;
         $display("FAIL %s req at done: got rd=%b wr=%b want 0 0", name, read_o, write_o); end
      if (address_o !== 32'h0) begin errors++;
         $display("FAIL %s address_o at done: got %h want 0", name, address_o); end
      if (resp_count - start_resp !== 1) begin errors++;
         $display("FAIL %s resp pulses: got %0d want 1", name, resp_count - start_resp); end

      read_i = 1'b0; write_i = 1'b0;
      step();
      checks += 2;
      if (resp_o !== 1'b0) begin errors++;
         $display("FAIL %s resp_o width: got %b want 0", name, resp_o); end
      if (line_o !== exp_line) begin errors++;
         $display("FAIL %s line_o idle hold: got %h want %h", name, line_o, exp_line); end

      if (tail) begin
         // Stray memory strobes while idle must not disturb anything.
         resp_i = 1'b1; burst_i = {$urandom, $urandom};
         step();
         step();
         resp_i = 1'b0;
         checks += 2;
         if (line_o !== exp_line) begin errors++;
            $display("FAIL %s idle resp_i line_o: got %h want %h", name, line_o, exp_line); end
         if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin errors++;
            $display("FAIL %s idle resp_i outputs: got rd=%b wr=%b resp=%b want 0 0 0",
                     name, read_o, write_o, resp_o); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      address_i = '0; line_i = '0; burst_i = '0;
      step(); step();
      rst = 1'b0;
      step();
      checks += 3;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin errors++;
         $display("FAIL reset ctrl: got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
      if (address_o !== 32'h0 || burst_o !== 64'h0) begin errors++;
         $display("FAIL reset addr/burst: got %h %h want 0 0", address_o, burst_o); end
      if (line_o !== 256'h0) begin errors++;
         $display("FAIL reset line_o: got %h want 0", line_o); end
   endtask

   task automatic test_read_nogap();
      logic [63:0] beats [4] = '{64'h1111_0000_0000_00A0, 64'h2222_0000_0000_00A1,
                                 64'h3333_0000_0000_00A2, 64'h4444_0000_0000_00A3};
      int gaps [4] = '{0, 0, 0, 0};
      run_txn("read_nogap", 1'b1, 1'b0, 32'h0000_1234, rand_line(), beats, gaps, -1, 1'b1);
   endtask

   task automatic test_read_gaps();
      logic [63:0] beats [4] = '{64'h1111_0000_0000_00A0, 64'h2222_0000_0000_00A1,
                                 64'h3333_0000_0000_00A2, 64'h4444_0000_0000_00A3};
      int gaps [4] = '{0, 2, 2, 2};
      run_txn("read_gaps", 1'b1, 1'b0, 32'h0000_1234, rand_line(), beats, gaps, -1, 1'b1);
   endtask

   task automatic test_write();
      logic [63:0] beats [4] = '{64'h0, 64'h0, 64'h0, 64'h0};
      int gaps [4] = '{0, 0, 0, 0};
      run_txn("write", 1'b0, 1'b1, 32'h8000_0040, rand_line(), beats, gaps, -1, 1'b1);
   endtask

   task automatic test_simultaneous();
      logic [63:0] beats [4];
      int gaps [4] = '{1, 0, 0, 1};
      for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
      run_txn("simultaneous", 1'b1, 1'b1, $urandom, rand_line(), beats, gaps, -1, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [63:0] beats [4];
      int gaps [4] = '{0, 0, 0, 0};
      int start;
      for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
      start = resp_count;
      run_txn("b2b_read", 1'b1, 1'b0, $urandom, rand_line(), beats, gaps, -1, 1'b0);
      run_txn("b2b_write", 1'b0, 1'b1, $urandom, rand_line(), beats, gaps, -1, 1'b1);
      checks++;
      if (resp_count - start !== 2) begin errors++;
         $display("FAIL back_to_back pulses: got %0d want 2", resp_count - start); end
   endtask

   task automatic test_drop_request();
      logic [63:0] beats [4];
      int gaps [4] = '{0, 1, 0, 2};
      for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
      run_txn("drop_read", 1'b1, 1'b0, $urandom, rand_line(), beats, gaps, 1, 1'b1);
      run_txn("drop_write", 1'b0, 1'b1, $urandom, rand_line(), beats, gaps, 0, 1'b1);
   endtask

   task automatic test_reset_mid_read();
      int start;
      start = resp_count;
      read_i = 1'b1; address_i = 32'h0000_5678; resp_i = 1'b0;
      step();
      for (int b = 0; b < 2; b++) begin
         resp_i = 1'b1; burst_i = {$urandom, $urandom};
         step();
      end
      resp_i = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; read_i = 1'b0;
      checks += 3;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin errors++;
         $display("FAIL rst_mid ctrl: got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
      if (address_o !== 32'h0) begin errors++;
         $display("FAIL rst_mid address_o: got %h want 0", address_o); end
      if (line_o !== 256'h0) begin errors++;
         $display("FAIL rst_mid line_o: got %h want 0", line_o); end
      for (int i = 0; i < 6; i++) begin
         resp_i = 1'b1; burst_i = {$urandom, $urandom};
         step();
      end
      resp_i = 1'b0;
      checks += 2;
      if (read_o !== 1'b0 || line_o !== 256'h0) begin errors++;
         $display("FAIL rst_mid late beats: got rd=%b line=%h want 0 0", read_o, line_o); end
      if (resp_count !== start) begin errors++;
         $display("FAIL rst_mid resp pulses: got %0d want 0", resp_count - start); end
   endtask

   task automatic test_random();
      logic [63:0] beats [4];
      int gaps [4];
      bit rd, wr;
      int drop;
      for (int t = 0; t < 25; t++) begin
         for (int b = 0; b < 4; b++) begin
            beats[b] = {$urandom, $urandom};
            gaps[b]  = $urandom_range(0, 3);
         end
         rd   = 1'($urandom_range(0, 1));
         wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         drop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
         run_txn("random", rd, wr, $urandom, rand_line(), beats, gaps, drop, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_read_nogap();
      test_read_gaps();
      test_write();
      test_simultaneous();
      test_back_to_back();
      test_drop_request();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
